// File: rtl/amstrad_crtc.sv
`default_nettype none
// ==========================================================================
// amstrad_crtc : UM6845R (type 1) character-rate CRTC for the CPC gate array
// rev 1.0
// ==========================================================================
module amstrad_crtc #(
  parameter int HS_MIN   = 1,
  parameter int VS_LINES = 16
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        CE,
  input  logic        SEL_WE,
  input  logic        DAT_WE,
  input  logic        DAT_RE,
  input  logic [7:0]  DIN,
  output logic [7:0]  DOUT,
  output logic [13:0] MA,
  output logic [4:0]  RA,
  output logic        HSYNC,
  output logic        VSYNC,
  output logic        DE
);

  localparam logic [0:0] ST_NORMAL = 1'b0;
  localparam logic [0:0] ST_ADJUST = 1'b1;
  localparam logic [3:0] HS_MIN_W  = 4'(HS_MIN);
  localparam logic [4:0] VS_END    = 5'(VS_LINES);

  // R8, R10, R11 and R3[7:4] have no observable effect on a type 1 part, so they are not held
  logic [4:0]  idx;
  logic [7:0]  r0, r1, r2, r13, r15;
  logic [3:0]  r3_hsw;
  logic [6:0]  r4, r6, r7;
  logic [4:0]  r5, r9;
  logic [5:0]  r12, r14;

  logic [7:0]  hcc, hcc_nx;
  logic [4:0]  raster, ra_nx;
  logic [6:0]  vcc, vcc_nx;
  logic [4:0]  adj, adj_nx;
  logic [3:0]  hsw, hsw_nx, hs_width;
  logic [4:0]  vsw, vsw_nx;
  logic [13:0] row_ma, row_nx, ma_nx;
  logic [0:0]  state, state_nx;
  logic        line_end, newframe, hs_nx, vs_nx, de_nx;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      idx    <= 5'd0;
      r0     <= 8'd63;
      r1     <= 8'd40;
      r2     <= 8'd46;
      r3_hsw <= 4'hE;
      r4     <= 7'd38;
      r5     <= 5'd0;
      r6     <= 7'd25;
      r7     <= 7'd30;
      r9     <= 5'd7;
      r12    <= 6'h30;
      r13    <= 8'h00;
      r14    <= 6'h00;
      r15    <= 8'h00;
      DOUT   <= 8'h00;
    end else begin
      if (SEL_WE) idx <= DIN[4:0];
      if (DAT_WE) begin
        case (idx)
          5'd0:    r0     <= DIN;
          5'd1:    r1     <= DIN;
          5'd2:    r2     <= DIN;
          5'd3:    r3_hsw <= DIN[3:0];
          5'd4:    r4     <= DIN[6:0];
          5'd5:    r5     <= DIN[4:0];
          5'd6:    r6     <= DIN[6:0];
          5'd7:    r7     <= DIN[6:0];
          5'd9:    r9     <= DIN[4:0];
          5'd12:   r12    <= DIN[5:0];
          5'd13:   r13    <= DIN;
          5'd14:   r14    <= DIN[5:0];
          5'd15:   r15    <= DIN;
          default: ;
        endcase
      end
      if (DAT_RE) begin
        case (idx)
          5'd14:   DOUT <= {2'b00, r14};
          5'd15:   DOUT <= r15;
          default: DOUT <= 8'h00;
        endcase
      end
    end
  end

  always_comb begin
    if (r3_hsw == 4'd0)         hs_width = 4'd0;
    else if (r3_hsw < HS_MIN_W) hs_width = HS_MIN_W;
    else                        hs_width = r3_hsw;
  end

  // Equality compares only: a limit written below a live counter lets it run to its natural wrap
  always_comb begin
    line_end = (hcc == r0);
    hcc_nx   = line_end ? 8'd0 : hcc + 8'd1;
    ra_nx    = raster;
    vcc_nx   = vcc;
    adj_nx   = adj;
    row_nx   = row_ma;
    state_nx = state;
    newframe = 1'b0;
    if (line_end) begin
      if (state == ST_NORMAL) begin
        if (raster == r9) begin
          ra_nx = 5'd0;
          if (vcc == r4) begin
            if (r5 == 5'd0) begin
              newframe = 1'b1;
            end else begin
              state_nx = ST_ADJUST;
              adj_nx   = 5'd0;
            end
          end else begin
            vcc_nx = vcc + 7'd1;
            row_nx = row_ma + {6'd0, r1};
          end
        end else begin
          ra_nx = raster + 5'd1;
        end
      end else begin
        if (adj == r5 - 5'd1) begin
          newframe = 1'b1;
        end else begin
          ra_nx  = raster + 5'd1;
          adj_nx = adj + 5'd1;
        end
      end
    end
    if (newframe) begin
      vcc_nx   = 7'd0;
      ra_nx    = 5'd0;
      row_nx   = {r12, r13};
      state_nx = ST_NORMAL;
    end
    ma_nx = row_nx + {6'd0, hcc_nx};
    de_nx = (hcc_nx < r1) && (vcc_nx < r6) && (state_nx == ST_NORMAL);

    hs_nx  = HSYNC;
    hsw_nx = hsw;
    if (HSYNC) begin
      if ((hs_width == 4'd0) || (hsw + 4'd1 == hs_width)) hs_nx = 1'b0;
      else                                                  hsw_nx = hsw + 4'd1;
    end else if ((hcc_nx == r2) && (hs_width != 4'd0)) begin
      hs_nx  = 1'b1;
      hsw_nx = 4'd0;
    end

    vs_nx  = VSYNC;
    vsw_nx = vsw;
    if (line_end) begin
      if (VSYNC) begin
        if (vsw + 5'd1 == VS_END) vs_nx  = 1'b0;
        else                      vsw_nx = vsw + 5'd1;
      end else if ((vcc_nx == r7) && (ra_nx == 5'd0)) begin
        vs_nx  = 1'b1;
        vsw_nx = 5'd0;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      hcc    <= 8'd0;
      raster <= 5'd0;
      vcc    <= 7'd0;
      adj    <= 5'd0;
      hsw    <= 4'd0;
      vsw    <= 5'd0;
      row_ma <= 14'h3000;
      state  <= ST_NORMAL;
      MA     <= 14'h3000;
      RA     <= 5'd0;
      HSYNC  <= 1'b0;
      VSYNC  <= 1'b0;
      DE     <= 1'b0;
    end else if (CE) begin
      hcc    <= hcc_nx;
      raster <= ra_nx;
      vcc    <= vcc_nx;
      adj    <= adj_nx;
      hsw    <= hsw_nx;
      vsw    <= vsw_nx;
      row_ma <= row_nx;
      state  <= state_nx;
      MA     <= ma_nx;
      RA     <= ra_nx;
      HSYNC  <= hs_nx;
      VSYNC  <= vs_nx;
      DE     <= de_nx;
    end
  end

endmodule
`default_nettype wire
